// File: rtl/stage_modulator_fb.sv
// Phase-modulation stage of the FM voice pipeline: adds scaled operator outputs of the same voice
// and operator self-feedback to each slot's raw phase. Owns algorithm/history storage and a post-reset clear.
module stage_modulator_fb #(
    parameter int NUM_OPS       = 8,
    parameter int NUM_VOICES    = 16,
    parameter int PHASE_W       = 16,
    parameter int SAMPLE_W      = 16,
    parameter int MOD_SHIFT     = 1,
    parameter int FB_BASE_SHIFT = 8,
    localparam int ID_W         = $clog2(NUM_OPS * NUM_VOICES),
    localparam int CAR_W        = $clog2(NUM_OPS + 1),
    localparam int ALG_W        = NUM_OPS + 3 + 1 + CAR_W
) (
    input  logic                i_Clock,
    input  logic                i_Reset_n,
    output logic                o_Ready,
    input  logic                i_Valid,
    input  logic [ID_W-1:0]     i_VoiceOperator,
    input  logic [PHASE_W-1:0]  i_Phase,
    output logic                o_Valid,
    output logic [ID_W-1:0]     o_VoiceOperator,
    output logic [PHASE_W-1:0]  o_Phase,
    output logic                o_IsACarrier,
    output logic [CAR_W-1:0]    o_NumCarriers,
    input  logic                i_WritebackValid,
    input  logic [ID_W-1:0]     i_WritebackID,
    input  logic [SAMPLE_W-1:0] i_WritebackValue,
    input  logic [2:0]          i_AlgWriteEnable,
    input  logic [ID_W-1:0]     i_AlgWriteAddr,
    input  logic [ALG_W-1:0]    i_AlgWriteData
);

    localparam int SLOTS = NUM_OPS * NUM_VOICES;
    localparam int DEPTH = 2 ** ID_W;
    localparam int NSTG  = NUM_OPS + 2;
    // One bit per addressable ID, set only for IDs that map to a real slot.
    localparam logic [DEPTH-1:0] SLOT_OK   = {DEPTH{1'b1}} >> (DEPTH - SLOTS);
    localparam logic [ID_W-1:0]  LAST_SLOT = ID_W'(SLOTS - 1);

    typedef struct packed {
        logic [CAR_W-1:0]   num_carriers;
        logic               is_carrier;
        logic [2:0]         fb_level;
        logic [NUM_OPS-1:0] mask;
    } alg_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W-1:0]     id;
        logic [PHASE_W-1:0]  phase;
        alg_t                alg;
        logic [SAMPLE_W-1:0] h0_own;
        logic [SAMPLE_W-1:0] h1_own;
    } slot_t;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                ready_q, ready_d;
    logic                clearing;

    logic [SAMPLE_W-1:0] h0_q [DEPTH];
    logic [SAMPLE_W-1:0] h0_d [DEPTH];
    logic [SAMPLE_W-1:0] h1_q [DEPTH];
    logic [SAMPLE_W-1:0] h1_d [DEPTH];
    alg_t                alg_q [DEPTH];
    alg_t                alg_d [DEPTH];
    alg_t                alg_wr;

    slot_t               pipe_q [NSTG];
    slot_t               pipe_d [NSTG];

    logic                out_valid_q, out_valid_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic [PHASE_W-1:0]  out_phase_q, out_phase_d;
    logic                out_car_q, out_car_d;
    logic [CAR_W-1:0]    out_ncar_q, out_ncar_d;

    function automatic logic signed [PHASE_W:0] sext(input logic [SAMPLE_W-1:0] s);
        return {{(PHASE_W + 1 - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    function automatic logic [PHASE_W-1:0] mod_term(input logic [SAMPLE_W-1:0] s);
        logic signed [PHASE_W:0] t;
        t = sext(s) >>> MOD_SHIFT;
        return PHASE_W'(t);
    endfunction

    function automatic logic [PHASE_W-1:0] fb_term(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b,
                                                   input logic [2:0]          lvl);
        logic signed [PHASE_W:0] t;
        int                      sh;
        sh = FB_BASE_SHIFT - int'(lvl);
        t  = (sext(a) + sext(b)) >>> sh;
        return PHASE_W'(t);
    endfunction

    function automatic logic [ID_W-1:0] peer_addr(input logic [ID_W-1:0] id, input int op);
        int a;
        a = (int'(id) / NUM_OPS) * NUM_OPS + op;
        return ID_W'(a);
    endfunction

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_SLOT) state_d = ST_RUN;
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        clearing = (state_q == ST_CLEAR);
        ready_d  = (state_q == ST_RUN);
    end

    // Clear and run-time writes are mutually exclusive; nothing is written while reset is held.
    always_comb begin
        h0_d   = h0_q;
        h1_d   = h1_q;
        alg_d  = alg_q;
        alg_wr = alg_t'(i_AlgWriteData);
        if (i_Reset_n) begin
            if (clearing) begin
                h0_d[clr_cnt_q]  = '0;
                h1_d[clr_cnt_q]  = '0;
                alg_d[clr_cnt_q] = '0;
            end else begin
                if (i_WritebackValid && SLOT_OK[i_WritebackID]) begin
                    h1_d[i_WritebackID] = h0_q[i_WritebackID];
                    h0_d[i_WritebackID] = i_WritebackValue;
                end
                if (SLOT_OK[i_AlgWriteAddr]) begin
                    if (i_AlgWriteEnable[0]) alg_d[i_AlgWriteAddr].mask     = alg_wr.mask;
                    if (i_AlgWriteEnable[1]) alg_d[i_AlgWriteAddr].fb_level = alg_wr.fb_level;
                    if (i_AlgWriteEnable[2]) begin
                        alg_d[i_AlgWriteAddr].is_carrier   = alg_wr.is_carrier;
                        alg_d[i_AlgWriteAddr].num_carriers = alg_wr.num_carriers;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        h0_q  <= h0_d;
        h1_q  <= h1_d;
        alg_q <= alg_d;
    end

    // Stage k reads operator k-1 of the slot's voice from the live history, so a same-edge
    // writeback is not yet visible to it.
    always_comb begin
        pipe_d[0]        = '0;
        pipe_d[0].valid  = i_Valid && ready_q;
        pipe_d[0].id     = i_VoiceOperator;
        pipe_d[0].phase  = i_Phase;
        pipe_d[0].alg    = alg_q[i_VoiceOperator];
        pipe_d[0].h0_own = h0_q[i_VoiceOperator];
        pipe_d[0].h1_own = h1_q[i_VoiceOperator];
        for (int k = 1; k <= NUM_OPS; k++) begin
            pipe_d[k] = pipe_q[k-1];
            if (pipe_q[k-1].alg.mask[k-1]) begin
                pipe_d[k].phase = pipe_q[k-1].phase
                                + mod_term(h0_q[peer_addr(pipe_q[k-1].id, k - 1)]);
            end
        end
        pipe_d[NSTG-1] = pipe_q[NUM_OPS];
        if (pipe_q[NUM_OPS].alg.fb_level != 3'd0) begin
            pipe_d[NSTG-1].phase = pipe_q[NUM_OPS].phase
                                 + fb_term(pipe_q[NUM_OPS].h0_own, pipe_q[NUM_OPS].h1_own,
                                           pipe_q[NUM_OPS].alg.fb_level);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            for (int k = 0; k < NSTG; k++) pipe_q[k].valid <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    always_comb begin
        out_valid_d = pipe_q[NSTG-1].valid;
        out_id_d    = out_id_q;
        out_phase_d = out_phase_q;
        out_car_d   = out_car_q;
        out_ncar_d  = out_ncar_q;
        if (pipe_q[NSTG-1].valid) begin
            out_id_d    = pipe_q[NSTG-1].id;
            out_phase_d = pipe_q[NSTG-1].phase;
            out_car_d   = pipe_q[NSTG-1].alg.is_carrier;
            out_ncar_d  = pipe_q[NSTG-1].alg.num_carriers;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_phase_q <= '0;
            out_car_q   <= 1'b0;
            out_ncar_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_phase_q <= out_phase_d;
            out_car_q   <= out_car_d;
            out_ncar_q  <= out_ncar_d;
        end
    end

    assign o_Ready         = ready_q;
    assign o_Valid         = out_valid_q;
    assign o_VoiceOperator = out_id_q;
    assign o_Phase         = out_phase_q;
    assign o_IsACarrier    = out_car_q;
    assign o_NumCarriers   = out_ncar_q;

endmodule

// File: tb/tb_stage_modulator_fb.sv
// Directed bench for stage_modulator_fb: clear timing, modulation arithmetic, feedback,
// read/write collision, back-to-back slots and mid-stream reset.
module tb_stage_modulator_fb;

    localparam int NUM_OPS = 8;
    localparam int LAT     = NUM_OPS + 2;
    localparam int CLR_RDY = 8 * 16 + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_ready;
    logic        i_valid;
    logic [6:0]  i_id;
    logic [15:0] i_phase;
    logic        o_valid;
    logic [6:0]  o_id;
    logic [15:0] o_phase;
    logic        o_car;
    logic [3:0]  o_ncar;
    logic        wb_valid;
    logic [6:0]  wb_id;
    logic [15:0] wb_value;
    logic [2:0]  alg_en;
    logic [6:0]  alg_addr;
    logic [15:0] alg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_modulator_fb dut (
        .i_Clock          (clk),
        .i_Reset_n        (rst_n),
        .o_Ready          (o_ready),
        .i_Valid          (i_valid),
        .i_VoiceOperator  (i_id),
        .i_Phase          (i_phase),
        .o_Valid          (o_valid),
        .o_VoiceOperator  (o_id),
        .o_Phase          (o_phase),
        .o_IsACarrier     (o_car),
        .o_NumCarriers    (o_ncar),
        .i_WritebackValid (wb_valid),
        .i_WritebackID    (wb_id),
        .i_WritebackValue (wb_value),
        .i_AlgWriteEnable (alg_en),
        .i_AlgWriteAddr   (alg_addr),
        .i_AlgWriteData   (alg_data)
    );

    function automatic logic [15:0] alg_word(input logic [3:0] ncar, input logic car,
                                             input logic [2:0] fb, input logic [7:0] mask);
        return {ncar, car, fb, mask};
    endfunction

    task automatic do_wb(input logic [6:0] id, input logic [15:0] v);
        @(negedge clk);
        wb_valid = 1'b1; wb_id = id; wb_value = v;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic do_alg(input logic [2:0] en, input logic [6:0] addr, input logic [15:0] data);
        @(negedge clk);
        alg_en = en; alg_addr = addr; alg_data = data;
        @(negedge clk);
        alg_en = 3'b000;
    endtask

    // Sends one slot, then samples o_Valid one cycle before and exactly at the expected latency.
    task automatic run_slot(input logic [6:0] id, input logic [15:0] ph,
                            output logic early, output logic late, output logic [15:0] oph,
                            output logic [6:0] oid, output logic ocar, output logic [3:0] oncar);
        @(negedge clk);
        i_valid = 1'b1; i_id = id; i_phase = ph;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 early = o_valid;
        @(posedge clk);
        #1;
        late = o_valid; oph = o_phase; oid = o_id; ocar = o_car; oncar = o_ncar;
    endtask

    // Releases reset and counts edges until o_Ready, noting any o_Valid seen on the way.
    task automatic clear_and_count(output int rdy_at, output logic early_valid);
        rdy_at = -1;
        early_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (o_valid !== 1'b0) early_valid = 1'b1;
            if (o_ready === 1'b1) begin
                rdy_at = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b1; i_id = 7'd3; i_phase = 16'hABCD;
        wb_valid = 1'b0; wb_id = '0; wb_value = '0;
        alg_en = 3'b000; alg_addr = '0; alg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", o_ready); end
        checks++; if (o_phase !== 16'h0000) begin errors++; $display("[TB] FAIL rst_phase: got %h expected 0000", o_phase); end
        checks++; if (o_id !== 7'd0) begin errors++; $display("[TB] FAIL rst_id: got %0d expected 0", o_id); end
        checks++; if (o_car !== 1'b0) begin errors++; $display("[TB] FAIL rst_car: got %b expected 0", o_car); end
        checks++; if (o_ncar !== 4'd0) begin errors++; $display("[TB] FAIL rst_ncar: got %0d expected 0", o_ncar); end
    endtask

    task automatic test_clear_timing();
        int   rdy_at;
        int   first_valid;
        logic early;
        clear_and_count(rdy_at, early);
        checks++; if (rdy_at != CLR_RDY) begin errors++; $display("[TB] FAIL clr_ready_cycle: got %0d expected %0d", rdy_at, CLR_RDY); end
        checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL clr_no_valid: got %b expected 0", early); end
        first_valid = -1;
        for (int c = rdy_at + 1; c <= rdy_at + 40; c++) begin
            @(posedge clk);
            #1;
            if (o_valid === 1'b1) begin
                first_valid = c;
                break;
            end
        end
        checks++; if (first_valid != CLR_RDY + 1 + LAT) begin errors++; $display("[TB] FAIL clr_first_valid: got %0d expected %0d", first_valid, CLR_RDY + 1 + LAT); end
        checks++; if (o_phase !== 16'hABCD) begin errors++; $display("[TB] FAIL clr_first_phase: got %h expected abcd", o_phase); end
        checks++; if (o_id !== 7'd3) begin errors++; $display("[TB] FAIL clr_first_id: got %0d expected 3", o_id); end
        @(negedge clk);
        i_valid = 1'b0;
        repeat (LAT + 2) @(posedge clk);
    endtask

    task automatic test_passthrough();
        logic e, l, c;
        logic [15:0] p;
        logic [6:0] id;
        logic [3:0] n;
        run_slot(7'd5, 16'h1234, e, l, p, id, c, n);
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL pass_early: got %b expected 0", e); end
        checks++; if (l !== 1'b1) begin errors++; $display("[TB] FAIL pass_valid: got %b expected 1", l); end
        checks++; if (p !== 16'h1234) begin errors++; $display("[TB] FAIL pass_phase: got %h expected 1234", p); end
        checks++; if (id !== 7'd5) begin errors++; $display("[TB] FAIL pass_id: got %0d expected 5", id); end
        checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL pass_car: got %b expected 0", c); end
        do_alg(3'b100, 7'd5, alg_word(4'd3, 1'b1, 3'd7, 8'hFF));
        run_slot(7'd5, 16'h1234, e, l, p, id, c, n);
        checks++; if (p !== 16'h1234) begin errors++; $display("[TB] FAIL field_only_phase: got %h expected 1234", p); end
        checks++; if (c !== 1'b1) begin errors++; $display("[TB] FAIL field_car: got %b expected 1", c); end
        checks++; if (n !== 4'd3) begin errors++; $display("[TB] FAIL field_ncar: got %0d expected 3", n); end
    endtask

    task automatic test_modulation_wrap();
        logic e, l, c;
        logic [15:0] p;
        logic [6:0] id;
        logic [3:0] n;
        do_wb(7'd10, 16'h0400);
        do_alg(3'b001, 7'd8, alg_word(4'd0, 1'b0, 3'd0, 8'h04));
        run_slot(7'd8, 16'hFF00, e, l, p, id, c, n);
        checks++; if (l !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid: got %b expected 1", l); end
        checks++; if (p !== 16'h0100) begin errors++; $display("[TB] FAIL wrap_phase: got %h expected 0100", p); end
        checks++; if (id !== 7'd8) begin errors++; $display("[TB] FAIL wrap_id: got %0d expected 8", id); end
    endtask

    task automatic test_negative_mod();
        logic e, l, c;
        logic [15:0] p;
        logic [6:0] id;
        logic [3:0] n;
        do_wb(7'd11, 16'hF800);
        do_alg(3'b001, 7'd9, alg_word(4'd0, 1'b0, 3'd0, 8'h08));
        run_slot(7'd9, 16'h0100, e, l, p, id, c, n);
        checks++; if (p !== 16'hFD00) begin errors++; $display("[TB] FAIL neg_phase: got %h expected fd00", p); end
        do_alg(3'b001, 7'd12, alg_word(4'd0, 1'b0, 3'd0, 8'h0C));
        run_slot(7'd12, 16'h0300, e, l, p, id, c, n);
        checks++; if (p !== 16'h0100) begin errors++; $display("[TB] FAIL two_mod_phase: got %h expected 0100", p); end
    endtask

    task automatic test_feedback();
        logic e, l, c;
        logic [15:0] p;
        logic [6:0] id;
        logic [3:0] n;
        do_wb(7'd20, 16'h1000);
        do_wb(7'd20, 16'h1000);
        do_alg(3'b010, 7'd20, alg_word(4'd0, 1'b0, 3'd7, 8'h00));
        run_slot(7'd20, 16'h0005, e, l, p, id, c, n);
        checks++; if (p !== 16'h1005) begin errors++; $display("[TB] FAIL fb7_phase: got %h expected 1005", p); end
        do_alg(3'b010, 7'd20, alg_word(4'd0, 1'b0, 3'd0, 8'hFF));
        run_slot(7'd20, 16'h0005, e, l, p, id, c, n);
        checks++; if (p !== 16'h0005) begin errors++; $display("[TB] FAIL fb0_phase: got %h expected 0005", p); end
        do_alg(3'b001, 7'd20, alg_word(4'd0, 1'b0, 3'd7, 8'h10));
        run_slot(7'd20, 16'h0005, e, l, p, id, c, n);
        checks++; if (p !== 16'h0805) begin errors++; $display("[TB] FAIL own_mask_phase: got %h expected 0805", p); end
        do_alg(3'b011, 7'd20, alg_word(4'd0, 1'b0, 3'd7, 8'h10));
        run_slot(7'd20, 16'h0005, e, l, p, id, c, n);
        checks++; if (p !== 16'h1805) begin errors++; $display("[TB] FAIL own_mask_fb_phase: got %h expected 1805", p); end
        do_wb(7'd20, 16'h0400);
        do_alg(3'b011, 7'd20, alg_word(4'd0, 1'b0, 3'd5, 8'h00));
        run_slot(7'd20, 16'h0005, e, l, p, id, c, n);
        checks++; if (p !== 16'h0285) begin errors++; $display("[TB] FAIL fb5_phase: got %h expected 0285", p); end
    endtask

    task automatic test_collision();
        do_wb(7'd24, 16'h0100);
        do_alg(3'b001, 7'd25, alg_word(4'd0, 1'b0, 3'd0, 8'h01));
        // Writeback lands on the edge where stage 1 latches its read of slot 24.
        @(negedge clk);
        i_valid = 1'b1; i_id = 7'd25; i_phase = 16'h0000;
        @(negedge clk);
        i_valid = 1'b0;
        wb_valid = 1'b1; wb_id = 7'd24; wb_value = 16'h0300;
        @(negedge clk);
        wb_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL coll_valid: got %b expected 1", o_valid); end
        checks++; if (o_phase !== 16'h0080) begin errors++; $display("[TB] FAIL coll_old_value: got %h expected 0080", o_phase); end
        // Writeback one edge earlier than the stage-1 read is visible to it.
        @(negedge clk);
        i_valid = 1'b1; i_id = 7'd25; i_phase = 16'h0000;
        wb_valid = 1'b1; wb_id = 7'd24; wb_value = 16'h0500;
        @(negedge clk);
        i_valid = 1'b0; wb_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        checks++; if (o_phase !== 16'h0280) begin errors++; $display("[TB] FAIL coll_new_value: got %h expected 0280", o_phase); end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  b_id  [4];
        logic [15:0] b_ph  [4];
        logic [15:0] b_exp [4];
        b_id[0] = 7'd5;  b_ph[0] = 16'h1000; b_exp[0] = 16'h1000;
        b_id[1] = 7'd8;  b_ph[1] = 16'h2000; b_exp[1] = 16'h2200;
        b_id[2] = 7'd9;  b_ph[2] = 16'h3000; b_exp[2] = 16'h2C00;
        b_id[3] = 7'd20; b_ph[3] = 16'h4000; b_exp[3] = 16'h4280;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_id = b_id[i]; i_phase = b_ph[i];
        end
        @(negedge clk);
        i_valid = 1'b0;
        repeat (LAT - 3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(posedge clk);
            #1;
            checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, o_valid); end
            checks++; if (o_id !== b_id[i]) begin errors++; $display("[TB] FAIL b2b_id[%0d]: got %0d expected %0d", i, o_id, b_id[i]); end
            checks++; if (o_phase !== b_exp[i]) begin errors++; $display("[TB] FAIL b2b_phase[%0d]: got %h expected %h", i, o_phase, b_exp[i]); end
        end
        @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", o_valid); end
    endtask

    task automatic test_reset_midstream();
        int   rdy_at;
        logic early;
        logic e, l, c;
        logic [15:0] p;
        logic [6:0] id;
        logic [3:0] n;
        @(negedge clk);
        i_valid = 1'b1; i_id = 7'd8; i_phase = 16'h0000;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_stream_valid: got %b expected 1", o_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b expected 0", o_ready); end
        checks++; if (o_phase !== 16'h0000) begin errors++; $display("[TB] FAIL mid_rst_phase: got %h expected 0000", o_phase); end
        repeat (2) @(posedge clk);
        clear_and_count(rdy_at, early);
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (rdy_at != CLR_RDY) begin errors++; $display("[TB] FAIL mid_ready_cycle: got %0d expected %0d", rdy_at, CLR_RDY); end
        checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_valid: got %b expected 0", early); end
        run_slot(7'd8, 16'hFF00, e, l, p, id, c, n);
        checks++; if (l !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_valid: got %b expected 1", l); end
        checks++; if (p !== 16'hFF00) begin errors++; $display("[TB] FAIL mid_alg_cleared: got %h expected ff00", p); end
        run_slot(7'd5, 16'h0042, e, l, p, id, c, n);
        checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL mid_car_cleared: got %b expected 0", c); end
    endtask

    initial begin
        test_reset();
        test_clear_timing();
        test_passthrough();
        test_modulation_wrap();
        test_negative_mod();
        test_feedback();
        test_collision();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
